booth_mul_arbiter: RTL and testbench

Two-requester front end and sequencer for the iterative radix-2 Booth multiplier. It arbitrates round-robin between two clients, captures the winner's operands, and runs one Booth recode/add/arithmetic-shift step per clock for WIDTH cycles. It then holds the signed 2·WIDTH-bit product and the winner's ID until the product is acknowledged. It sits between the ALU issue logic and the shared multiplier resource, so only one multiply is ever in flight.

---
 rtl/booth_mul_arbiter.sv | 130 +++++++++++++
 tb/tb_booth_mul_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin two-client front end and radix-2 Booth sequencer (one step per clock).
// Optional build macro BOOTH_ZERO_SKIP_EN: a zero operand bypasses iteration and completes at once.
module booth_mul_arbiter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req,
   input  logic [WIDTH-1:0]   x0,
   input  logic [WIDTH-1:0]   y0,
   input  logic [WIDTH-1:0]   x1,
   input  logic [WIDTH-1:0]   y1,
   output logic [1:0]         gnt,
   output logic               busy,
   output logic               done,
   output logic               done_id,
   output logic [2*WIDTH-1:0] z,
   input  logic               ack
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t             state_q;
   logic               ptr_q;
   logic [WIDTH-1:0]   x_q, y_q;
   logic [2*WIDTH-1:0] acc_q;
   logic               e_q;
   logic [CW-1:0]      cnt_q;
   logic               done_id_q, busy_q, done_q;

   logic               hs, hs_id;
   logic [WIDTH-1:0]   sel_x, sel_y;
   logic [WIDTH:0]     upper_ext, y_ext, sum_d;
   logic [2*WIDTH-1:0] acc_d;

   always_comb begin
      gnt = '0;
      if (rst_n && state_q == S_IDLE) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = '0;
         endcase
      end
   end

   assign hs    = |gnt;
   assign hs_id = gnt[1];
   assign sel_x = hs_id ? x1 : x0;
   assign sel_y = hs_id ? y1 : y0;

   // Upper half widened by one bit so subtracting the most negative Y cannot overflow;
   // the widened sum then shifts straight down into the 2*WIDTH accumulator.
   always_comb begin
      upper_ext = {acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
      y_ext     = {y_q[WIDTH-1], y_q};
      unique case ({x_q[cnt_q], e_q})
         2'b01:   sum_d = upper_ext + y_ext;
         2'b10:   sum_d = upper_ext - y_ext;
         default: sum_d = upper_ext;
      endcase
      acc_d = {sum_d, acc_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         acc_q     <= '0;
         e_q       <= 1'b0;
         cnt_q     <= '0;
         done_id_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (hs) begin
                  x_q       <= sel_x;
                  y_q       <= sel_y;
                  done_id_q <= hs_id;
                  acc_q     <= '0;
                  e_q       <= 1'b0;
                  cnt_q     <= '0;
                  ptr_q     <= ~hs_id;
                  busy_q    <= 1'b1;
`ifdef BOOTH_ZERO_SKIP_EN
                  if (sel_x == '0 || sel_y == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ITER;
                  end
`else
                  state_q   <= S_ITER;
`endif
               end
            end
            S_ITER: begin
               acc_q <= acc_d;
               e_q   <= x_q[cnt_q];
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               if (ack) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign z       = acc_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed + randomized bench for booth_mul_arbiter against a plain-arithmetic product/round-robin model.
module tb_booth_mul_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [15:0] x0, y0, x1, y1;
   logic [1:0]  gnt;
   logic        busy, done, done_id, ack;
   logic [31:0] z;

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;

   booth_mul_arbiter #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
      .z(z), .ack(ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'h0001;
         2:       return 16'hFFFF;
         3:       return 16'h8000;
         4:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic do_op(input logic [1:0] rq, input int ackwait, input bit hold_req);
      int n, lat, ex_lat, a, b;
      logic [15:0] xs, ys;
      logic [31:0] ez;
      req = rq;
      #1;
      chk("idle_busy", 64'(busy), 64'd0);
      n  = (rq == 2'b01) ? 0 : (rq == 2'b10) ? 1 : ptr_m;
      chk("gnt", 64'(gnt), 64'(2'b01 << n));
      xs = (n == 1) ? x1 : x0;
      ys = (n == 1) ? y1 : y0;
      a  = int'($signed(xs));
      b  = int'($signed(ys));
      ez = 32'(a * b);
      ex_lat = 16;
`ifdef BOOTH_ZERO_SKIP_EN
      if (xs == 16'd0 || ys == 16'd0) ex_lat = 0;
`endif
      tick();
      ptr_m = 1 - n;
      if (!hold_req) req = 2'b00;
      x0 = 16'($urandom); y0 = 16'($urandom);
      x1 = 16'($urandom); y1 = 16'($urandom);
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         chk("iter_gnt", 64'(gnt), 64'd0);
         chk("iter_busy", 64'(busy), 64'd1);
         tick();
         lat++;
      end
      chk("latency", 64'(lat), 64'(ex_lat));
      chk("z", 64'(z), 64'(ez));
      chk("done_id", 64'(done_id), 64'(n));
      repeat (ackwait) begin
         tick();
         chk("stall_done", 64'(done), 64'd1);
         chk("stall_z", 64'(z), 64'(ez));
         chk("stall_id", 64'(done_id), 64'(n));
         chk("stall_gnt", 64'(gnt), 64'd0);
         chk("stall_busy", 64'(busy), 64'd1);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("done_drop", 64'(done), 64'd0);
      chk("busy_drop", 64'(busy), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; req = 2'b11; ack = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      repeat (3) tick();
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_id", 64'(done_id), 64'd0);
      chk("rst_z", 64'(z), 64'd0);
      req = 2'b00;
      rst_n = 1'b1;
      tick();

      // basic signs, ack ignored outside DONE
      ack = 1'b1; tick(); ack = 1'b0;
      chk("ack_idle_busy", 64'(busy), 64'd0);
      x0 = 16'd3; y0 = 16'hFFFB;
      do_op(2'b01, 0, 1'b0);

      // most-negative corners on client 1
      x1 = 16'h8000; y1 = 16'h8000;
      do_op(2'b10, 0, 1'b0);
      x1 = 16'h8000; y1 = 16'h0001;
      do_op(2'b10, 0, 1'b0);

      // contention: req held high, immediate ack
      for (int i = 0; i < 4; i++) do_op(2'b11, 0, 1'b1);

      // backpressure
      x0 = 16'd1000; y0 = 16'hFC18; x1 = 16'd77; y1 = 16'd99;
      do_op(2'b11, 10, 1'b0);

      // request withdrawn before the edge: no handshake, pointer untouched
      req = 2'b11; #1;
      req = 2'b00;
      tick();
      chk("withdraw_busy", 64'(busy), 64'd0);
      do_op(2'b11, 0, 1'b0);

      // zero operand
      x0 = 16'd0; y0 = 16'd1234;
      do_op(2'b01, 0, 1'b0);

      // reset during iteration
      x0 = 16'd100; y0 = 16'hFFF9;
      req = 2'b01; #1;
      chk("mid_gnt", 64'(gnt), 64'd1);
      tick();
      ptr_m = 1;
      req = 2'b00;
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      ptr_m = 0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_z", 64'(z), 64'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("abort_nodone", 64'(done), 64'd0);
      end
      x0 = 16'd5; y0 = 16'd6; x1 = 16'd7; y1 = 16'd8;
      do_op(2'b11, 0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 12; i++) begin
         x0 = rnd_op(); y0 = rnd_op(); x1 = rnd_op(); y1 = rnd_op();
         do_op(2'($urandom_range(1, 3)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
